// File: rtl/sub_bcd_decoder_pkg.sv
// -----------------------------------------------------------------------------
// sub_bcd_decoder_pkg
// Shared definitions for the subtractor-result BCD decoder:
//   - FSM state encoding (IDLE / CONV / DONE)
//   - default input width and BCD digit count
//   - BCD digit width
//   - pow10(): constant helper used for the elaboration-time range check
// No ports (package).
// -----------------------------------------------------------------------------
package sub_bcd_decoder_pkg;

    localparam int W_DEF    = 6;
    localparam int NDIG_DEF = 2;
    localparam int DIG_W    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_bcd_decoder_if.sv
// -----------------------------------------------------------------------------
// sub_bcd_decoder_if
// Handshake bundle between the subtractor result producer / display consumer
// (master) and the BCD decoder (slave).
//   in_valid  : master -> slave, in_data is valid
//   in_ready  : slave  -> master, decoder can accept a word
//   in_data   : master -> slave, W-bit two's-complement difference
//   out_valid : slave  -> master, sign/bcd are valid
//   out_ready : master -> slave, consumer takes the result
//   sign      : slave  -> master, 1 = negative
//   bcd       : slave  -> master, magnitude digits, [3:0] = ones
// -----------------------------------------------------------------------------
interface sub_bcd_decoder_if
    import sub_bcd_decoder_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF
);

    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sign;
    logic [DIG_W*NDIG-1:0] bcd;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sign, bcd
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sign, bcd
    );

endinterface

// File: rtl/sub_bcd_decoder_bcd_add3_step.sv
// -----------------------------------------------------------------------------
// bcd_add3_step
// Combinational double-dabble correction for one BCD digit: digits of 5 or
// more get +3 so that the following left shift carries correctly into the
// next decade.
//   digit : input  DIG_W, scratch digit before the shift
//   adj   : output DIG_W, corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_step
    import sub_bcd_decoder_pkg::*;
(
    input  logic [DIG_W-1:0] digit,
    output logic [DIG_W-1:0] adj
);

    assign adj = (digit >= DIG_W'(5)) ? digit + DIG_W'(3) : digit;

endmodule

// File: rtl/sub_bcd_decoder.sv
// -----------------------------------------------------------------------------
// sub_bcd_decoder
// Converts one W-bit two's-complement difference into sign + NDIG BCD digits
// using one shift-add-3 step per clock. One conversion in flight at a time.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high, highest priority
//   bus : sub_bcd_decoder_if.slave (input handshake + result handshake)
// Latency: accept at edge k, out_valid after edge k+W. Throughput 1 / (W+2).
// -----------------------------------------------------------------------------
module sub_bcd_decoder
    import sub_bcd_decoder_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDIG = NDIG_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    sub_bcd_decoder_if.slave  bus
);

    localparam int BCD_W = DIG_W * NDIG;
    localparam int CNT_W = $clog2(W + 1);

    // The largest magnitude, 2^(W-1) from the most negative input, must fit.
    generate
        if ((1 << (W - 1)) >= pow10(NDIG)) begin : g_range_chk
            $error("sub_bcd_decoder: NDIG too small for W");
        end
    endgenerate

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       mag;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_r;
    logic               sign_work;
    logic               sign_r;
    logic [BCD_W+W-1:0] shifted;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        bcd_add3_step u_step (
            .digit (scratch[g*DIG_W +: DIG_W]),
            .adj   (adj[g*DIG_W +: DIG_W])
        );
    end

    // Correct every digit first, then shift the whole {scratch, mag} pair.
    assign shifted = {adj, mag} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mag       <= '0;
            scratch   <= '0;
            sign_work <= 1'b0;
            sign_r    <= 1'b0;
            bcd_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Sign is kept aside so the visible SIGN only
                        // changes together with BCD when DONE is entered.
                        sign_work <= bus.in_data[W-1];
                        // Unsigned W-bit negate: -2^(W-1) maps to 2^(W-1).
                        mag       <= bus.in_data[W-1] ? -bus.in_data : bus.in_data;
                        scratch   <= '0;
                        cnt       <= '0;
                        state     <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    scratch <= shifted[BCD_W+W-1 -: BCD_W];
                    mag     <= shifted[W-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(W - 1)) begin
                        bcd_r  <= shifted[BCD_W+W-1 -: BCD_W];
                        sign_r <= sign_work;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sign      = sign_r;
    assign bus.bcd       = bcd_r;

endmodule

// File: tb/tb_sub_bcd_decoder.sv
// -----------------------------------------------------------------------------
// tb_sub_bcd_decoder
// Self-checking bench for sub_bcd_decoder: directed cases, backpressure,
// mid-conversion reset, full 64-value sweep and randomized backpressure,
// all compared with an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_sub_bcd_decoder;

    localparam int W    = 6;
    localparam int NDIG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    time  acc_t  = 0;

    sub_bcd_decoder_if #(.W(W), .NDIG(NDIG)) bus ();

    sub_bcd_decoder #(.W(W), .NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed value -> sign flag and decimal digits of |value|.
    function automatic logic model_sign(input logic [5:0] d);
        return (int'($signed(d)) < 0);
    endfunction

    function automatic logic [7:0] model_bcd(input logic [5:0] d);
        int v;
        int m;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // Called at a negedge; returns just after the accepting posedge.
    task automatic send(input logic [5:0] d);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        acc_t = $time;
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 6'($urandom);
    endtask

    // Waits for out_valid (bounded), checks latency and result; ends at a negedge.
    task automatic wait_out(input logic [5:0] d, input string tag);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(W));
        check({tag, "_sign"}, 32'(bus.sign), 32'(model_sign(d)));
        check({tag, "_bcd"}, 32'(bus.bcd), 32'(model_bcd(d)));
    endtask

    // With out_ready high in DONE: one edge back to IDLE; ends at a negedge.
    task automatic handshake_idle(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [5:0] dir_d    [7] = '{6'b000110, 6'b111010, 6'b110001, 6'b001111,
                                 6'b100000, 6'b011111, 6'b000000};
    logic       dir_sign [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] dir_bcd  [7] = '{8'h06, 8'h06, 8'h15, 8'h15, 8'h32, 8'h31, 8'h00};

    initial begin
        logic [5:0] d;
        logic       hold_sign;
        logic [7:0] hold_bcd;
        time        t_prev;
        int         k;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sign", 32'(bus.sign), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        rst = 1'b0;

        // Directed values with fixed expectations
        for (int i = 0; i < 7; i++) begin
            send(dir_d[i]);
            wait_out(dir_d[i], "directed");
            check("directed_sign_table", 32'(bus.sign), 32'(dir_sign[i]));
            check("directed_bcd_table", 32'(bus.bcd), 32'(dir_bcd[i]));
            handshake_idle("directed");
        end

        // Backpressure: 5 cycles in DONE with new data offered
        bus.out_ready = 1'b0;
        send(6'b110001);
        wait_out(6'b110001, "bp");
        hold_sign = bus.sign;
        hold_bcd  = bus.bcd;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = 6'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_sign_hold", 32'(bus.sign), 32'd1);
            check("bp_bcd_hold", 32'(bus.bcd), 32'h15);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        handshake_idle("bp_release");
        check("post_hs_sign_hold", 32'(bus.sign), 32'(hold_sign));
        check("post_hs_bcd_hold", 32'(bus.bcd), 32'(hold_bcd));

        // Reset during the third CONV cycle
        send(6'b011111);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sign", 32'(bus.sign), 32'd0);
        check("midrst_bcd", 32'(bus.bcd), 32'd0);
        send(6'b111010);
        wait_out(6'b111010, "after_rst");
        check("after_rst_sign_fixed", 32'(bus.sign), 32'd1);
        check("after_rst_bcd_fixed", 32'(bus.bcd), 32'h06);
        handshake_idle("after_rst");

        // Exhaustive back-to-back sweep
        for (int v = 0; v < 64; v++) begin
            t_prev = acc_t;
            send(6'(v));
            if (v > 0) begin
                check("sweep_throughput", 32'((acc_t - t_prev) / 10), 32'(W + 2));
            end
            wait_out(6'(v), "sweep");
            handshake_idle("sweep");
        end

        // Random values with random backpressure length
        for (int i = 0; i < 16; i++) begin
            d = 6'($urandom);
            bus.out_ready = 1'b0;
            send(d);
            wait_out(d, "rand");
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) begin
                @(posedge clk);
                @(negedge clk);
                check("rand_hold_bcd", 32'(bus.bcd), 32'(model_bcd(d)));
                check("rand_hold_valid", 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
            handshake_idle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
